usb_in_stream_packer: RTL and testbench

USB_IN_STREAM_PACKER -- requirements
Module: usb_in_stream_packer

---
 rtl/usb_in_stream_packer.sv | 72 +++++++
 tb/tb_usb_in_stream_packer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_in_stream_packer.sv
// usb_in_stream_packer: packs a byte stream into USB IN packets, committing when full or after an idle timeout; define USB_IN_STREAM_ZLP_EN to send a zero-length packet after a full packet goes idle
module usb_in_stream_packer #(
  parameter int MAX_PACKET_SIZE = 32,
  parameter int FLUSH_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  input  logic       in_ep_acked,
  output logic       busy
);
  localparam int CW = $clog2(MAX_PACKET_SIZE + 1);
  localparam int IW = $clog2(FLUSH_TIMEOUT + 1);
  typedef enum logic [1:0] {FILL, COMMIT, WAIT_ACK} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [IW-1:0] idle;
  logic tmo;
  logic zlp;
  assign s_ready = !reset && state == FILL && in_ep_data_free && count < CW'(MAX_PACKET_SIZE);
  assign in_ep_data_put = s_valid && s_ready;
  assign in_ep_data = s_data;
  assign in_ep_data_done = !reset && state == COMMIT;
  assign busy = !reset && state != FILL;
  // the idle counter reaches FLUSH_TIMEOUT on this cycle's increment
  assign tmo = int'(idle) + 1 >= FLUSH_TIMEOUT;
`ifdef USB_IN_STREAM_ZLP_EN
  logic last_full;
  assign zlp = count == '0 && last_full && in_ep_data_free && tmo;
  // remember whether the last committed packet was full, so an idle stream ends it with a ZLP
  always_ff @(posedge clk) begin
    if (reset) last_full <= 1'b0;
    else if (state == COMMIT) last_full <= count == CW'(MAX_PACKET_SIZE);
  end
`else
  assign zlp = 1'b0;
`endif
  // packet FSM: fill until full or idle timeout, pulse done for one cycle, then wait for the host ACK
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      count <= '0;
      idle <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_ep_data_put) begin
            count <= count + 1'b1;
            idle <= '0;
            if (count == CW'(MAX_PACKET_SIZE - 1)) state <= COMMIT;
          end else begin
            if (idle != IW'(FLUSH_TIMEOUT)) idle <= idle + 1'b1;
            if ((count != '0 && tmo) || zlp) state <= COMMIT;
          end
        end
        COMMIT: begin
          state <= WAIT_ACK;
          count <= '0;
          idle <= '0;
        end
        WAIT_ACK: state <= in_ep_acked ? FILL : WAIT_ACK;
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_in_stream_packer.sv
// tb_usb_in_stream_packer: directed self-checking bench, MAX_PACKET_SIZE=32, FLUSH_TIMEOUT=8
module tb_usb_in_stream_packer;
  localparam int MAX = 32;
  localparam int FT = 8;
  logic clk = 0;
  logic reset = 1;
  logic [7:0] s_data = 0;
  logic s_valid = 0;
  logic s_ready;
  logic free = 1;
  logic put;
  logic [7:0] ep_data;
  logic done;
  logic acked = 0;
  logic busy;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int puts = 0;
  int dones = 0;

  usb_in_stream_packer #(.MAX_PACKET_SIZE(MAX), .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .in_ep_data_free(free), .in_ep_data_put(put), .in_ep_data(ep_data),
    .in_ep_data_done(done), .in_ep_acked(acked), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (put) puts <= puts + 1;
    if (done) dones <= dones + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1;
    s_valid = 0;
    acked = 0;
    free = 1;
    tick;
    tick;
    reset = 0;
  endtask

  task automatic ack;
    acked = 1;
    tick;
    acked = 0;
  endtask

  // returns the cycle on which done was seen, or -1 if the budget ran out
  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) at = cyc;
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1;
    s_valid = 1;
    s_data = 8'h3C;
    tick;
    tick;
    @(negedge clk);
    checks++;
    if ({s_ready, put, done, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got ready/put/done/busy=%b expected 0000", {s_ready, put, done, busy});
    end
    checks++;
    if (ep_data !== 8'h3C) begin
      errors++;
      $display("FAIL reset_data_follow: got %h expected 3c", ep_data);
    end
    @(posedge clk);
    #1;
    reset = 0;
    s_valid = 0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", s_ready, busy);
    end
    tick;
  endtask

  task automatic test_burst5;
    int last;
    int at;
    int p0;
    logic ok;
    do_reset;
    p0 = puts;
    last = 0;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(i + 1);
      s_valid = 1;
      @(negedge clk);
      checks++;
      if (put !== 1'b1 || ep_data !== 8'(i + 1)) begin
        errors++;
        $display("FAIL burst5_put%0d: got put=%b data=%h expected put=1 data=%h", i, put, ep_data, 8'(i + 1));
      end
      last = cyc;
      tick;
    end
    s_valid = 0;
    wait_done(20, at);
    checks++;
    if (at - last !== FT + 1) begin
      errors++;
      $display("FAIL burst5_done_delay: got %0d cycles expected %0d", at - last, FT + 1);
    end
    checks++;
    if (puts - p0 !== 5) begin
      errors++;
      $display("FAIL burst5_put_count: got %0d expected 5", puts - p0);
    end
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0 || s_ready !== 1'b0) ok = 0;
      tick;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL burst5_wait_ack: got busy/done/ready off-pattern expected busy=1 done=0 ready=0");
    end
    ack;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL burst5_after_ack: got busy=%b ready=%b expected busy=0 ready=1", busy, s_ready);
    end
    tick;
  endtask

  task automatic test_full32;
    int p0;
    logic ok;
    do_reset;
    p0 = puts;
    for (int i = 0; i < MAX; i++) begin
      s_data = 8'(i);
      s_valid = 1;
      @(negedge clk);
      checks++;
      if (put !== 1'b1 || ep_data !== 8'(i)) begin
        errors++;
        $display("FAIL full32_put%0d: got put=%b data=%h expected put=1 data=%h", i, put, ep_data, 8'(i));
      end
      tick;
    end
    s_data = 8'd33;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || s_ready !== 1'b0 || put !== 1'b0) begin
      errors++;
      $display("FAIL full32_commit: got done=%b ready=%b put=%b expected 1 0 0", done, s_ready, put);
    end
    tick;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || put !== 1'b0 || busy !== 1'b1 || done !== 1'b0) ok = 0;
      tick;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full32_hold: got ready/put/busy/done off-pattern expected 0 0 1 0");
    end
    ack;
    @(negedge clk);
    checks++;
    if (put !== 1'b1 || ep_data !== 8'd33) begin
      errors++;
      $display("FAIL full32_byte33: got put=%b data=%h expected put=1 data=21", put, ep_data);
    end
    tick;
    s_valid = 0;
    checks++;
    if (puts - p0 !== MAX + 1) begin
      errors++;
      $display("FAIL full32_put_count: got %0d expected %0d", puts - p0, MAX + 1);
    end
  endtask

  task automatic test_slow;
    int d0;
    logic ok;
    do_reset;
    d0 = dones;
    ok = 1;
    for (int i = 0; i < MAX; i++) begin
      s_data = 8'(8'h40 + i);
      s_valid = 1;
      @(negedge clk);
      if (put !== 1'b1 || ep_data !== 8'(8'h40 + i)) ok = 0;
      tick;
      s_valid = 0;
      if (i < MAX - 1) repeat (6) tick;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL slow_puts: got a missed or wrong put expected every offered byte put");
    end
    checks++;
    if (dones - d0 !== 0) begin
      errors++;
      $display("FAIL slow_early_commit: got %0d dones expected 0", dones - d0);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL slow_full_commit: got done=%b expected 1", done);
    end
    tick;
    ack;
  endtask

  task automatic test_put_on_timeout;
    int t1;
    int at;
    do_reset;
    s_data = 8'h77;
    s_valid = 1;
    tick;
    s_valid = 0;
    repeat (7) tick;
    s_data = 8'h78;
    s_valid = 1;
    @(negedge clk);
    t1 = cyc;
    checks++;
    if (put !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_put: got put=%b done=%b expected put=1 done=0", put, done);
    end
    tick;
    s_valid = 0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_put_wins: got done=%b busy=%b expected 0 0", done, busy);
    end
    tick;
    wait_done(20, at);
    checks++;
    if (at - t1 !== FT + 1) begin
      errors++;
      $display("FAIL timeout_restart: got %0d cycles expected %0d", at - t1, FT + 1);
    end
    ack;
  endtask

  task automatic test_backpressure;
    logic ok;
    do_reset;
    free = 0;
    s_valid = 1;
    s_data = 8'hA5;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (put !== 1'b0 || s_ready !== 1'b0) ok = 0;
      tick;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL backpressure_hold: got a put while free=0 expected none");
    end
    free = 1;
    @(negedge clk);
    checks++;
    if (put !== 1'b1 || ep_data !== 8'hA5) begin
      errors++;
      $display("FAIL backpressure_release: got put=%b data=%h expected put=1 data=a5", put, ep_data);
    end
    tick;
    s_valid = 0;
  endtask

  task automatic test_reset_wait;
    int at;
    int d0;
    logic ok;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'(8'h90 + i);
      s_valid = 1;
      tick;
    end
    s_valid = 0;
    wait_done(20, at);
    tick;
    @(negedge clk);
    checks++;
    if (at < 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_enter: got done_at=%0d busy=%b expected done seen and busy=1", at, busy);
    end
    tick;
    reset = 1;
    tick;
    reset = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_state: got busy=%b ready=%b expected busy=0 ready=1", busy, s_ready);
    end
    tick;
    d0 = dones;
    ack;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) ok = 0;
      tick;
    end
    checks++;
    if (!ok || dones - d0 !== 0) begin
      errors++;
      $display("FAIL rstwait_ack_ignored: got dones=%0d busy_ok=%b expected 0 1", dones - d0, ok);
    end
    for (int i = 0; i < 3; i++) begin
      s_data = 8'(8'hB0 + i);
      s_valid = 1;
      tick;
    end
    s_valid = 0;
    repeat (3) tick;
    reset = 1;
    tick;
    reset = 0;
    d0 = dones;
    wait_done(20, at);
    checks++;
    if (at !== -1 || dones - d0 !== 0) begin
      errors++;
      $display("FAIL rstfill_discard: got done_at=%0d expected -1", at);
    end
  endtask

  task automatic test_zlp;
    int at;
    int a;
    int p0;
    do_reset;
    for (int i = 0; i < MAX; i++) begin
      s_data = 8'(8'hC0 + i);
      s_valid = 1;
      tick;
    end
    s_valid = 0;
    wait_done(5, at);
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL zlp_first_done: got none expected done");
    end
    ack;
    a = cyc;
    p0 = puts;
`ifdef USB_IN_STREAM_ZLP_EN
    wait_done(20, at);
    checks++;
    if (at - a !== FT || puts - p0 !== 0) begin
      errors++;
      $display("FAIL zlp_second_done: got delay=%0d puts=%0d expected delay=%0d puts=0", at - a, puts - p0, FT);
    end
    ack;
    wait_done(30, at);
    checks++;
    if (at !== -1) begin
      errors++;
      $display("FAIL zlp_third_done: got done_at=%0d expected -1", at);
    end
`else
    wait_done(30, at);
    checks++;
    if (at !== -1 || puts - p0 !== 0) begin
      errors++;
      $display("FAIL zlp_off_no_done: got done_at=%0d puts=%0d expected -1 0", at, puts - p0);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_burst5;
    test_full32;
    test_slow;
    test_put_on_timeout;
    test_backpressure;
    test_reset_wait;
    test_zlp;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
